gray_ptr_sync_rx: RTL and testbench

//  Receiving end of a gray-coded counter/pointer crossing into this clock domain.

---
 rtl/gray_ptr_sync_rx.sv | 204 ++++++++++++++++++++
 tb/tb_gray_ptr_sync_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_sync_rx.sv
// -----------------------------------------------------------------------------
// gray_ptr_sync_rx
//
// Receiving end of a gray-coded pointer crossing into this clock domain.
// The incoming gray word is passed through a flip-flop synchronizer, decoded
// to binary, and compared with the previous decode. This produces a per-cycle
// delta and an advance flag. With the checker built, the block also flags any
// gray step that changes more than one bit. Typical use is on the read side
// of a clock-crossing FIFO or a status counter.
//
// Parameters
//   WIDTH        pointer width in bits (>= 2)
//   SYNC_STAGES  synchronizer depth in flip-flops (>= 2)
//
// Ports
//   i_clk         destination-domain clock
//   i_n_rst       asynchronous active-low reset
//   i_gray_in     gray pointer from the source domain (asynchronous)
//   i_clear       synchronous re-acquire; acts like reset, except that the
//                 synchronizer chain keeps its contents
//   o_gray_sync   last synchronizer stage (gray)
//   o_bin_out     registered binary decode of o_gray_sync
//   o_delta       (o_bin_out - previous o_bin_out) mod 2^WIDTH, registered
//   o_advance     1 for one cycle when o_delta != 0 (only while o_valid)
//   o_valid       o_bin_out / o_delta are meaningful
//   o_err         one-cycle pulse on an illegal (multi-bit) gray step
//   o_err_sticky  latched o_err; cleared only by i_n_rst or i_clear
//
// Build option
//   GRAY_PTR_RX_ERR_CHECK_EN
//     defined   : builds the previous-gray register and the multi-bit step
//                 checker. The FAULT state is reachable.
//     undefined : builds no checker. o_err and o_err_sticky are tied to 0,
//                 and the FSM has only ACQ and TRACK. All other timing is
//                 identical.
// -----------------------------------------------------------------------------
module gray_ptr_sync_rx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_n_rst,
    input  logic [WIDTH-1:0] i_gray_in,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_gray_sync,
    output logic [WIDTH-1:0] o_bin_out,
    output logic [WIDTH-1:0] o_delta,
    output logic             o_advance,
    output logic             o_valid,
    output logic             o_err,
    output logic             o_err_sticky
);

    // The acquisition counter must be able to hold SYNC_STAGES.
    localparam int                CNT_W    = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [CNT_W-1:0]  ACQ_LAST = CNT_W'(SYNC_STAGES);

    localparam logic [1:0] ST_ACQ   = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
`ifdef GRAY_PTR_RX_ERR_CHECK_EN
    localparam logic [1:0] ST_FAULT = 2'd2;
`endif

    // Decode: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

`ifdef GRAY_PTR_RX_ERR_CHECK_EN
    // Returns true when popcount(x) > 1. The expression x & (x-1) clears the
    // lowest set bit, so any bit left over means at least two bits were set.
    function automatic logic multi_bit(input logic [WIDTH-1:0] x);
        return |(x & (x - WIDTH'(1)));
    endfunction
`endif

    logic [WIDTH-1:0] r_sync_p0 [SYNC_STAGES];
    logic [WIDTH-1:0] r_bin_p1;
    logic [WIDTH-1:0] r_delta_p1;
    logic             r_adv_p1;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_acq_cnt;

    logic [WIDTH-1:0] w_gray_sync;
    logic [WIDTH-1:0] w_bin_p0;
    logic [WIDTH-1:0] w_delta_p0;

    // ---- stage p0: synchronizer chain (plain shift; i_clear leaves it alone)
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_p0[i] <= '0;
            end
        end else begin
            r_sync_p0[0] <= i_gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_p0[i] <= r_sync_p0[i-1];
            end
        end
    end

    assign w_gray_sync = r_sync_p0[SYNC_STAGES-1];
    assign w_bin_p0    = gray2bin(w_gray_sync);
    // Modulo subtraction, so a step from all-ones to 0 gives +1 and a
    // backwards step gives 2^WIDTH-1.
    assign w_delta_p0  = w_bin_p0 - r_bin_p1;

`ifdef GRAY_PTR_RX_ERR_CHECK_EN
    logic [WIDTH-1:0] r_prev_gray_p0;
    logic             r_err_p1;
    logic             r_err_sticky;
    logic             w_multi_p0;

    // Tracks gray_sync one cycle behind. It is not touched by i_clear,
    // because the checker is masked in ACQ anyway.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_prev_gray_p0 <= '0;
        end else begin
            r_prev_gray_p0 <= w_gray_sync;
        end
    end

    assign w_multi_p0 = multi_bit(w_gray_sync ^ r_prev_gray_p0);
`endif

    // ---- stage p1: decode, delta and the control FSM
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_bin_p1     <= '0;
            r_delta_p1   <= '0;
            r_adv_p1     <= 1'b0;
            r_state      <= ST_ACQ;
            r_acq_cnt    <= '0;
`ifdef GRAY_PTR_RX_ERR_CHECK_EN
            r_err_p1     <= 1'b0;
            r_err_sticky <= 1'b0;
`endif
        end else if (i_clear) begin
            // When i_clear coincides with an illegal step, the clear takes
            // priority and no error is recorded.
            r_bin_p1     <= '0;
            r_delta_p1   <= '0;
            r_adv_p1     <= 1'b0;
            r_state      <= ST_ACQ;
            r_acq_cnt    <= '0;
`ifdef GRAY_PTR_RX_ERR_CHECK_EN
            r_err_p1     <= 1'b0;
            r_err_sticky <= 1'b0;
`endif
        end else begin
            r_bin_p1 <= w_bin_p0;
            case (r_state)
                ST_ACQ: begin
                    // Wait until the synchronizer has flushed and bin_out
                    // holds a real sample. The first sample never counts as
                    // a step.
                    r_delta_p1 <= '0;
                    r_adv_p1   <= 1'b0;
`ifdef GRAY_PTR_RX_ERR_CHECK_EN
                    r_err_p1   <= 1'b0;
`endif
                    if (r_acq_cnt == ACQ_LAST) begin
                        r_state <= ST_TRACK;
                    end else begin
                        r_acq_cnt <= r_acq_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // TRACK and FAULT decode identically. FAULT only keeps
                    // the sticky flag set until a clear or reset.
                    r_delta_p1 <= w_delta_p0;
                    r_adv_p1   <= |w_delta_p0;
`ifdef GRAY_PTR_RX_ERR_CHECK_EN
                    r_err_p1   <= w_multi_p0;
                    if (w_multi_p0) begin
                        r_err_sticky <= 1'b1;
                        r_state      <= ST_FAULT;
                    end
`endif
                end
            endcase
        end
    end

    assign o_gray_sync  = w_gray_sync;
    assign o_bin_out    = r_bin_p1;
    assign o_delta      = r_delta_p1;
    assign o_advance    = r_adv_p1;
    assign o_valid      = (r_state != ST_ACQ);
`ifdef GRAY_PTR_RX_ERR_CHECK_EN
    assign o_err        = r_err_p1;
    assign o_err_sticky = r_err_sticky;
`else
    assign o_err        = 1'b0;
    assign o_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_gray_ptr_sync_rx
//
// Scoreboard bench for gray_ptr_sync_rx (WIDTH=4, SYNC_STAGES=2).
// The stimulus process drives gray_in, clear and n_rst. For each action it
// queues the full output snapshot expected at a given cycle. The monitor
// samples outputs on the falling edge and pops due entries. It also flags any
// advance or err pulse that no entry predicted.
// Error expectations follow GRAY_PTR_RX_ERR_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_gray_ptr_sync_rx;

`ifdef GRAY_PTR_RX_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] gray_in;
    logic       clear;
    logic [3:0] gray_sync;
    logic [3:0] bin_out;
    logic [3:0] delta;
    logic       advance;
    logic       valid;
    logic       err;
    logic       err_sticky;

    gray_ptr_sync_rx #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk        (clk),
        .i_n_rst      (n_rst),
        .i_gray_in    (gray_in),
        .i_clear      (clear),
        .o_gray_sync  (gray_sync),
        .o_bin_out    (bin_out),
        .o_delta      (delta),
        .o_advance    (advance),
        .o_valid      (valid),
        .o_err        (err),
        .o_err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      nm;
        logic [3:0] gs;
        logic [3:0] bin;
        logic [3:0] dl;
        logic       adv;
        logic       vld;
        logic       er;
        logic       st;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    logic exp_st;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic push(input int c, input string nm, input logic [3:0] gs,
                        input logic [3:0] b, input logic [3:0] d,
                        input logic adv, input logic vld,
                        input logic er, input logic st);
        exp_t e;
        e.cyc = c; e.nm = nm; e.gs = gs; e.bin = b; e.dl = d;
        e.adv = adv; e.vld = vld; e.er = er; e.st = st;
        sb.push_back(e);
    endtask

    // One gray step. The decode appears 3 cycles after the input changes,
    // and delta/advance fall back to 0 one cycle later.
    task automatic step(input logic [3:0] g, input logic [3:0] b,
                        input logic [3:0] d, input logic er,
                        input logic st, input string nm);
        int n;
        n = cyc;
        gray_in = g;
        push(n + 3, nm, g, b, d, (d != 4'd0), 1'b1, er, st);
        push(n + 4, {nm, "_hold"}, g, b, 4'd0, 1'b0, 1'b1, 1'b0, st);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        bit   hit;
        exp_t e;
        hit = 1'b0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            hit = 1'b1;
            checks++;
            if (e.cyc != cyc || gray_sync !== e.gs || bin_out !== e.bin ||
                delta !== e.dl || advance !== e.adv || valid !== e.vld ||
                err !== e.er || err_sticky !== e.st) begin
                errors++;
                $display("FAIL %s cyc=%0d actual gs=%h bin=%h delta=%h adv=%b vld=%b err=%b sticky=%b required(cyc=%0d) gs=%h bin=%h delta=%h adv=%b vld=%b err=%b sticky=%b",
                         e.nm, cyc, gray_sync, bin_out, delta, advance, valid, err, err_sticky,
                         e.cyc, e.gs, e.bin, e.dl, e.adv, e.vld, e.er, e.st);
            end
        end
        if (!hit && (advance !== 1'b0 || err !== 1'b0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event cyc=%0d actual adv=%b err=%b required adv=0 err=0",
                     cyc, advance, err);
        end
        if (done) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain actual pending=%0d required pending=0", sb.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // Stimulus.
    initial begin
        int r;
        int m;
        int n;
        n_rst   = 1'b0;
        gray_in = 4'b0000;
        clear   = 1'b0;
        exp_st  = 1'b0;

        // Reset state, then acquisition: valid rises 3 edges after release.
        repeat (2) @(posedge clk);
        #1;
        push(cyc, "reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        r = cyc;
        push(r + 2, "acq_wait", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(r + 3, "acq_done", 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Forward walk 1..5.
        for (int b = 1; b <= 5; b++) begin
            step(bin2gray(4'(b)), 4'(b), 4'd1, 1'b0, 1'b0, "walk");
        end

        // Asynchronous reset with bin_out=5, then reacquire gray 0111.
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        push(cyc, "async_rst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        m = cyc;
        push(m + 2, "reacq_wait", 4'b0111, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(m + 3, "reacq",      4'b0111, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(m + 4, "reacq_hold", 4'b0111, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;

        // Walk 6..15, wrap to 0, step backwards, forwards again, 0-bit step.
        for (int b = 6; b <= 15; b++) begin
            step(bin2gray(4'(b)), 4'(b), 4'd1, 1'b0, 1'b0, "walk_hi");
        end
        step(4'b0000, 4'd0,  4'd1,  1'b0, 1'b0, "wrap");
        step(4'b1000, 4'd15, 4'd15, 1'b0, 1'b0, "backward");
        step(4'b0000, 4'd0,  4'd1,  1'b0, 1'b0, "fwd_again");
        step(4'b0000, 4'd0,  4'd0,  1'b0, 1'b0, "zero_step");

        // Illegal 2-bit step, a legal step while faulted, another illegal step.
        exp_st = ERR_EN;
        step(4'b0011, 4'd2, 4'd2, ERR_EN, exp_st, "multi_bit");
        step(4'b0010, 4'd3, 4'd1, 1'b0,   exp_st, "fault_legal");
        step(4'b0101, 4'd6, 4'd3, ERR_EN, exp_st, "fault_multi");

        // clear lands on the same edge as an illegal 0101->0110 step.
        n = cyc;
        gray_in = 4'b0110;
        exp_st  = 1'b0;
        push(n + 3, "clear_edge",  4'b0110, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(n + 4, "clear_acq",   4'b0110, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(n + 6, "clear_reacq", 4'b0110, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Normal tracking after the clear: no sticky error left.
        step(4'b0111, 4'd5, 4'd1, 1'b0, 1'b0, "post_clear");

        repeat (3) @(posedge clk);
        #1;
        done = 1'b1;
    end

    // Run-time bound.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $finish;
    end

endmodule
